// File: rtl/hs_sync_tx.sv
// Four-phase request/acknowledge transmitter that launches one data word into a far clock domain.
// The acknowledge is synchronised locally, and a sticky flag reports a handshake phase that waits too long.
//
// state  | meaning
// IDLE   | waiting for a word; blocks new words while a stale ack is still high
// REQ_HI | cdc_req high, waiting for the synchronised ack to rise
// REQ_LO | cdc_req low, waiting for the synchronised ack to fall
module hs_sync_tx #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] src_data,
  input  logic                 src_valid,
  output logic                 src_ready,
  output logic [BUS_WIDTH-1:0] cdc_data,
  output logic                 cdc_req,
  input  logic                 cdc_ack,
  output logic                 done,
  output logic                 timeout
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_t;

  state_t                state;
  logic [NUM_STAGES-1:0] ack_sync;
  logic                  ack_s;
  logic [CNT_W-1:0]      phase_cnt;
  logic                  leaving;

  assign ack_s     = ack_sync[NUM_STAGES-1];
  assign src_ready = reset && (state == IDLE) && !ack_s;
  assign leaving   = ((state == REQ_HI) && ack_s) || ((state == REQ_LO) && !ack_s);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[NUM_STAGES-2:0], cdc_ack};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cdc_req   <= 1'b0;
      cdc_data  <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      phase_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (src_valid && src_ready) begin
            cdc_data <= src_data;
            cdc_req  <= 1'b1;
            state    <= REQ_HI;
          end
        end
        REQ_HI: begin
          if (ack_s) begin
            cdc_req <= 1'b0;
            state   <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (!ack_s) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          cdc_req <= 1'b0;
          state   <= IDLE;
        end
      endcase

      // Count wait cycles within one phase; any state change restarts the count.
      if ((state == IDLE) || leaving) begin
        phase_cnt <= '0;
      end else if (phase_cnt != CNT_MAX) begin
        phase_cnt <= phase_cnt + 1'b1;
      end

      if ((state != IDLE) && (phase_cnt == CNT_MAX)) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hs_sync_tx.sv
// Bench for hs_sync_tx: a directed vector table, randomized transfers checked against an arithmetic timing model,
// and hand-written sequences for stale acks, timeout and reset in the middle of a transfer.
module tb_hs_sync_tx;

  localparam int W  = 8;
  localparam int NS = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] src_data = '0;
  logic         src_valid = 1'b0;
  logic         src_ready;
  logic [W-1:0] cdc_data;
  logic         cdc_req;
  logic         cdc_ack;
  logic         done;
  logic         timeout;
  logic         echo = 1'b0;
  logic         ack_drv = 1'b0;

  logic [W-1:0] to_data = '0;
  logic         to_valid = 1'b0;
  logic         to_ready;
  logic [W-1:0] to_cdata;
  logic         to_req;
  logic         to_ack = 1'b0;
  logic         to_done;
  logic         to_timeout;

  always #5 clk = ~clk;

  // When echo is set, the far end acknowledges with zero delay.
  assign cdc_ack = echo ? cdc_req : ack_drv;

  hs_sync_tx #(.BUS_WIDTH(W), .NUM_STAGES(NS), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .cdc_data(cdc_data), .cdc_req(cdc_req),
    .cdc_ack(cdc_ack), .done(done), .timeout(timeout)
  );

  hs_sync_tx #(.BUS_WIDTH(W), .NUM_STAGES(NS), .TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset), .src_data(to_data), .src_valid(to_valid),
    .src_ready(to_ready), .cdc_data(to_cdata), .cdc_req(to_req),
    .cdc_ack(to_ack), .done(to_done), .timeout(to_timeout)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         e_req;
    logic [W-1:0] e_data;
    logic         e_done;
    logic         e_rdy;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic e_req,
                              input logic [W-1:0] e_data, input logic e_done, input logic e_rdy);
    vec_t r;
    r.v = v; r.d = d; r.e_req = e_req; r.e_data = e_data; r.e_done = e_done; r.e_rdy = e_rdy;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] last_word;
    int           seen_done;
    int           waited;

    // A zero-delay echo with two synchroniser stages gives: accept at row k, req falls at k+3, done at k+6.
    tbl[0]  = mk(1, 8'hA5, 1, 8'hA5, 0, 0);
    tbl[1]  = mk(0, 8'h3C, 1, 8'hA5, 0, 0);
    tbl[2]  = mk(0, 8'hC3, 1, 8'hA5, 0, 0);
    tbl[3]  = mk(1, 8'h77, 0, 8'hA5, 0, 0);
    tbl[4]  = mk(0, 8'h00, 0, 8'hA5, 0, 0);
    tbl[5]  = mk(1, 8'hFF, 0, 8'hA5, 0, 0);
    tbl[6]  = mk(0, 8'h11, 0, 8'hA5, 1, 1);
    tbl[7]  = mk(0, 8'h22, 0, 8'hA5, 0, 1);
    tbl[8]  = mk(1, 8'h01, 1, 8'h01, 0, 0);
    tbl[9]  = mk(1, 8'h02, 1, 8'h01, 0, 0);
    tbl[10] = mk(1, 8'h02, 1, 8'h01, 0, 0);
    tbl[11] = mk(1, 8'h02, 0, 8'h01, 0, 0);
    tbl[12] = mk(1, 8'h02, 0, 8'h01, 0, 0);
    tbl[13] = mk(1, 8'h02, 0, 8'h01, 0, 0);
    tbl[14] = mk(1, 8'h02, 0, 8'h01, 1, 1);
    tbl[15] = mk(1, 8'h02, 1, 8'h02, 0, 0);
    tbl[16] = mk(0, 8'h5A, 1, 8'h02, 0, 0);
    tbl[17] = mk(0, 8'h6B, 1, 8'h02, 0, 0);
    tbl[18] = mk(0, 8'h7C, 0, 8'h02, 0, 0);
    tbl[19] = mk(0, 8'h8D, 0, 8'h02, 0, 0);
    tbl[20] = mk(0, 8'h9E, 0, 8'h02, 0, 0);
    tbl[21] = mk(0, 8'hAF, 0, 8'h02, 1, 1);
    tbl[22] = mk(0, 8'hB0, 0, 8'h02, 0, 1);

    // Reset state
    src_data = 8'hEE;
    src_valid = 1'b1;
    step();
    step();
    check("reset_outputs", {src_ready, cdc_req, cdc_data, done, timeout}, 12'h000);
    check("reset_to_outputs", {to_ready, to_req, to_cdata, to_done, to_timeout}, 12'h000);
    src_valid = 1'b0;
    reset = 1'b1;
    step();
    check("idle_ready", {src_ready, cdc_req, done}, 3'b100);

    // Directed table: single transfer and back-to-back transfers with a zero-delay far end
    echo = 1'b1;
    for (int i = 0; i < 23; i++) begin
      src_valid = tbl[i].v;
      src_data  = tbl[i].d;
      step();
      check($sformatf("tbl_row%0d req,data,done,rdy", i),
            {cdc_req, cdc_data, done, src_ready},
            {tbl[i].e_req, tbl[i].e_data, tbl[i].e_done, tbl[i].e_rdy});
    end
    echo = 1'b0;
    src_valid = 1'b0;

    // Randomized transfers: far end delays d1/d2 cycles; timing follows from the handshake rules
    last_word = 8'h02;
    for (int t = 0; t < 30; t++) begin
      int gap, d1, d2, f, tt;
      logic [W-1:0] w;
      gap = $urandom_range(0, 3);
      d1  = $urandom_range(0, 6);
      d2  = $urandom_range(0, 6);
      w   = W'($urandom);
      for (int g = 0; g < gap; g++) begin
        src_valid = 1'b0;
        src_data  = W'($urandom);
        ack_drv   = 1'b0;
        step();
        check($sformatf("rnd%0d_gap req,data,done,rdy", t),
              {cdc_req, cdc_data, done, src_ready}, {1'b0, last_word, 1'b0, 1'b1});
      end
      src_valid = 1'b1;
      src_data  = w;
      step();
      last_word = w;
      f  = d1 + NS + 1;
      tt = d1 + d2 + 2 * NS + 2;
      for (int k = 0; k <= tt; k++) begin
        src_valid = (k < tt) ? 1'($urandom) : 1'b0;
        src_data  = W'($urandom);
        ack_drv   = (k >= d1) && (k < f + d2);
        check($sformatf("rnd%0d_k%0d req,data,done,rdy,tmo", t, k),
              {cdc_req, cdc_data, done, src_ready, timeout},
              {(k < f) ? 1'b1 : 1'b0, w, (k == tt) ? 1'b1 : 1'b0, (k == tt) ? 1'b1 : 1'b0, 1'b0});
        if (k < tt) step();
      end
    end
    src_valid = 1'b0;
    ack_drv = 1'b0;

    // Timeout with TIMEOUT=4: flag rises 5 cycles after accept, transfer still completes later
    to_valid = 1'b1;
    to_data  = 8'h5A;
    step();
    to_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("tmo_k%0d tmo,req,rdy", k), {to_timeout, to_req, to_ready},
            {(k >= 5) ? 1'b1 : 1'b0, 1'b1, 1'b0});
    end
    to_ack = 1'b1;
    waited = 0;
    while (to_req && waited < 20) begin
      step();
      waited++;
    end
    check("tmo_req_fall", to_req, 1'b0);
    to_ack = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (to_done) seen_done++;
    end
    check("tmo_done_count", seen_done, 1);
    check("tmo_sticky,rdy,data", {to_timeout, to_ready, to_cdata}, {1'b1, 1'b1, 8'h5A});

    // Stale ack held high across reset release
    reset = 1'b0;
    ack_drv = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    step();
    check("stale_rdy_low", src_ready, 1'b0);
    src_valid = 1'b1;
    src_data = 8'h44;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stale_hold%0d rdy,req", k), {src_ready, cdc_req}, 2'b00);
    end
    ack_drv = 1'b0;
    step();
    check("stale_fall1 rdy,req", {src_ready, cdc_req}, 2'b00);
    step();
    check("stale_fall2 rdy,req,data", {src_ready, cdc_req, cdc_data}, {1'b1, 1'b0, 8'h00});
    src_valid = 1'b0;
    step();
    check("stale_no_xfer req", cdc_req, 1'b0);

    // Reset while in REQ_LO
    src_valid = 1'b1;
    src_data = 8'h9C;
    step();
    src_valid = 1'b0;
    ack_drv = 1'b1;
    waited = 0;
    while (cdc_req && waited < 10) begin
      step();
      waited++;
    end
    check("midlo_req_fell", cdc_req, 1'b0);
    reset = 1'b0;
    step();
    check("midlo_reset req,data,done,rdy,tmo",
          {cdc_req, cdc_data, done, src_ready, timeout}, {1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    ack_drv = 1'b0;
    step();
    reset = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (done) seen_done++;
    end
    check("midlo_no_done", seen_done, 0);
    check("midlo_after rdy,req", {src_ready, cdc_req}, 2'b10);

    // Reset while in REQ_HI drops cdc_req on that edge
    src_valid = 1'b1;
    src_data = 8'h3B;
    step();
    src_valid = 1'b0;
    step();
    check("midhi_req_high", {cdc_req, cdc_data}, {1'b1, 8'h3B});
    reset = 1'b0;
    step();
    check("midhi_reset req,data,done", {cdc_req, cdc_data, done}, {1'b0, 8'h00, 1'b0});
    reset = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (done) seen_done++;
    end
    check("midhi_no_done", seen_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
